// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, one transaction in flight.
// Optional fetch anti-starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_funct3,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              stall_if
);

    localparam int unsigned CNT_W    = 2;
    localparam int unsigned STRK_W   = 4;
    localparam logic [2:0]  FETCH_F3 = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_kill;
    logic               r_store;
    logic               w_done;
    logic               w_free;
    logic               w_fetch_turn;
    logic               w_if_gnt;
    logic               w_d_gnt;
    logic               w_if_rv;
    logic               w_d_rv;

    // Completion is the last busy cycle; arbitration reopens in that same cycle.
    assign w_done = (r_state != IDLE) && (r_cnt == '0);
    assign w_free = rst && ((r_state == IDLE) || w_done);

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [STRK_W-1:0]  r_streak;

    assign w_fetch_turn = (r_streak == STRK_W'(STARVE_MAX));

    // Consecutive data grants taken while a fetch was waiting; saturates at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_streak <= '0;
        end else if (w_if_gnt) begin
            r_streak <= '0;
        end else if (w_d_gnt) begin
            if (!if_req)
                r_streak <= '0;
            else if (r_streak != STRK_W'(STARVE_MAX))
                r_streak <= r_streak + STRK_W'(1);
        end
    end
`else
    logic [STRK_W-1:0]  w_unused_starve;

    assign w_unused_starve = STRK_W'(STARVE_MAX);
    assign w_fetch_turn    = 1'b0;
`endif

    assign w_d_gnt  = w_free && d_req && !(if_req && w_fetch_turn);
    assign w_if_gnt = w_free && if_req && !w_d_gnt;
    assign w_if_rv  = w_done && (r_state == BUSY_I) && !r_kill && !if_kill;
    assign w_d_rv   = w_done && (r_state == BUSY_D);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_d_gnt)
            w_state_nxt = BUSY_D;
        else if (w_if_gnt)
            w_state_nxt = BUSY_I;
        else if (w_done)
            w_state_nxt = IDLE;
    end

    // Latency counter, fetch kill latch and load/store flag of the outstanding access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_kill  <= 1'b0;
            r_store <= 1'b0;
        end else begin
            if (w_if_gnt || w_d_gnt)
                r_cnt <= CNT_W'(MEM_LAT - 1);
            else if ((r_state != IDLE) && (r_cnt != '0))
                r_cnt <= r_cnt - CNT_W'(1);

            if (w_if_gnt)
                r_kill <= if_kill;
            else if (w_done)
                r_kill <= 1'b0;
            else if ((r_state == BUSY_I) && if_kill)
                r_kill <= 1'b1;

            if (w_d_gnt)
                r_store <= d_we;
        end
    end

    // Output logic
    always_comb begin
        if_gnt     = w_if_gnt;
        d_gnt      = w_d_gnt;
        stall_if   = rst && if_req && !w_if_gnt;
        mem_en     = w_if_gnt || w_d_gnt;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_funct3 = '0;
        mem_wdata  = '0;
        if (w_d_gnt) begin
            mem_we     = d_we;
            mem_addr   = d_addr;
            mem_funct3 = d_funct3;
            mem_wdata  = d_wdata;
        end else if (w_if_gnt) begin
            mem_addr   = if_addr;
            mem_funct3 = FETCH_F3;
        end
        if_rvalid  = w_if_rv;
        d_rvalid   = w_d_rv;
        if_rdata   = w_if_rv ? mem_rdata : '0;
        d_rdata    = (w_d_rv && !r_store) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus a randomized
// run checked every cycle against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int unsigned AW  = 10;
    localparam int unsigned LAT = 3;
    localparam int unsigned SM  = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_kill;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [2:0]    d_funct3;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_funct3;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          stall_if;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(
        .ADDR_W    (AW),
        .MEM_LAT   (LAT),
        .STARVE_MAX(SM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_funct3  (d_funct3),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_funct3(mem_funct3),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding access with an absolute completion cycle.
    int       cyc = 0;
    bit       m_busy, m_is_if, m_killed, m_store;
    int       m_done;
    int       m_streak;
    bit       m_if_gl, m_d_gl;
    bit       complete, free, fetch_first;
    bit       e_ig, e_dg, e_irv, e_drv;
    logic [AW-1:0] e_addr;
    logic [2:0]    e_f3;

    initial begin
        m_busy = 0; m_is_if = 0; m_killed = 0; m_store = 0;
        m_done = 0; m_streak = 0; m_if_gl = 0; m_d_gl = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("reset_outputs",
                    {if_gnt, d_gnt, if_rvalid, d_rvalid, stall_if, mem_en, mem_we,
                     mem_addr, mem_funct3, mem_wdata, if_rdata, d_rdata}, '0);
                m_busy = 0; m_streak = 0; m_if_gl = 0; m_d_gl = 0; m_killed = 0;
            end else begin
                complete    = m_busy && (cyc == m_done);
                free        = !m_busy || complete;
                fetch_first = GUARD && (m_streak == int'(SM));
                e_dg  = free && d_req && !(if_req && fetch_first);
                e_ig  = free && if_req && !e_dg;
                e_irv = complete && m_is_if && !m_killed && !if_kill;
                e_drv = complete && !m_is_if;
                e_addr = e_dg ? d_addr : (e_ig ? if_addr : '0);
                e_f3   = e_dg ? d_funct3 : (e_ig ? 3'b010 : 3'b000);

                chk("m_if_gnt",    if_gnt,     e_ig);
                chk("m_d_gnt",     d_gnt,      e_dg);
                chk("m_stall_if",  stall_if,   if_req && !e_ig);
                chk("m_mem_en",    mem_en,     e_ig || e_dg);
                chk("m_mem_we",    mem_we,     e_dg && d_we);
                chk("m_mem_addr",  mem_addr,   e_addr);
                chk("m_mem_f3",    mem_funct3, e_f3);
                chk("m_mem_wdata", mem_wdata,  e_dg ? d_wdata : 32'h0);
                chk("m_if_rvalid", if_rvalid,  e_irv);
                chk("m_d_rvalid",  d_rvalid,   e_drv);
                chk("m_if_rdata",  if_rdata,   e_irv ? mem_rdata : 32'h0);
                chk("m_d_rdata",   d_rdata,    (e_drv && !m_store) ? mem_rdata : 32'h0);

                if (complete) m_busy = 0;
                if (m_busy && m_is_if && if_kill) m_killed = 1;
                if (e_dg || e_ig) begin
                    m_busy   = 1;
                    m_is_if  = e_ig;
                    m_store  = e_dg && d_we;
                    m_done   = cyc + int'(LAT);
                    m_killed = e_ig && if_kill;
                end
                if (e_ig)
                    m_streak = 0;
                else if (e_dg)
                    m_streak = if_req ? ((m_streak + 1 > int'(SM)) ? int'(SM) : m_streak + 1) : 0;
                m_if_gl = e_ig;
                m_d_gl  = e_dg;
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        mem_rdata = $urandom;
    endtask

    task automatic idle(input int n);
        if_req = 0; d_req = 0; if_kill = 0;
        for (int k = 0; k < n; k++) step();
    endtask

    int n_d, n_i, first_i;

    initial begin
        rst = 0; if_req = 1; d_req = 1; if_kill = 0;
        if_addr = 10'h3FC; d_we = 1; d_funct3 = 3'b111; d_addr = 10'h155;
        d_wdata = 32'hFFFF_FFFF; mem_rdata = 32'h1234_5678;
        #2;
        chk("rst_gnt_blocked", {if_gnt, d_gnt, stall_if, mem_en, mem_we}, 5'b0);
        step(); step();
        rst = 1; if_req = 0; d_req = 0; d_we = 0; d_wdata = 0;
        idle(3);

        // Lone fetch: issued at once, data back after LAT cycles
        step(); if_req = 1; if_addr = 10'h010; #1;
        chk("fetch_gnt", {if_gnt, d_gnt, mem_en, mem_we, stall_if}, 5'b10100);
        chk("fetch_mem_addr", mem_addr, 10'h010);
        chk("fetch_mem_f3", mem_funct3, 3'b010);
        step(); if_req = 0; #1;
        chk("fetch_wait1_rvalid", if_rvalid, 1'b0);
        step(); #1;
        chk("fetch_wait2_rvalid", if_rvalid, 1'b0);
        step(); mem_rdata = 32'hCAFE_F00D; #1;
        chk("fetch_rvalid", if_rvalid, 1'b1);
        chk("fetch_rdata", if_rdata, 32'hCAFE_F00D);
        idle(3);

        // Store beats fetch; fetch issued in the store's completion cycle
        step();
        if_req = 1; if_addr = 10'h040;
        d_req = 1; d_we = 1; d_funct3 = 3'b010; d_addr = 10'h200; d_wdata = 32'hDEAD_BEEF; #1;
        chk("both_gnt", {d_gnt, if_gnt, stall_if, mem_we}, 4'b1011);
        chk("both_mem_addr", mem_addr, 10'h200);
        chk("both_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        step(); d_req = 0; d_we = 0; #1;
        chk("both_busy1", {if_gnt, stall_if, mem_en}, 3'b010);
        step(); #1;
        chk("both_busy2", {if_gnt, stall_if, mem_en}, 3'b010);
        step(); #1;
        chk("store_done", {d_rvalid, if_gnt, stall_if, mem_we}, 4'b1100);
        chk("store_rdata", d_rdata, 32'h0);
        chk("fetch_after_store_addr", mem_addr, 10'h040);
        idle(5);

        // Continuous contention: grant pattern over ten slots
        n_d = 0; n_i = 0; first_i = -1;
        for (int k = 0; k < 10 * int'(LAT); k++) begin
            step();
            if_req = 1; if_addr = 10'h020;
            d_req = 1; d_we = 0; d_funct3 = 3'b000; d_addr = 10'h300; d_wdata = 0; #1;
            if (d_gnt) n_d++;
            if (if_gnt) begin
                if (first_i < 0) first_i = n_d + n_i;
                n_i++;
            end
        end
        chk("starve_d_grants", n_d, GUARD ? 8 : 10);
        chk("starve_if_grants", n_i, GUARD ? 2 : 0);
        chk("starve_first_if", first_i + 1, GUARD ? 5 : 0);
        idle(5);

        // Kill during an outstanding fetch; pending load issued at completion
        step(); if_req = 1; if_addr = 10'h100; #1;
        chk("kill_fetch_gnt", if_gnt, 1'b1);
        step(); if_req = 0; if_kill = 1; d_req = 1; d_we = 0; d_addr = 10'h080; #1;
        chk("kill_busy_no_dgnt", d_gnt, 1'b0);
        step(); if_kill = 0; #1;
        step(); #1;
        chk("kill_no_rvalid", if_rvalid, 1'b0);
        chk("kill_load_gnt", {d_gnt, mem_en, mem_addr}, {2'b11, 10'h080});
        step(); d_req = 0;
        idle(5);

        // Reset in the middle of a data access
        step(); d_req = 1; d_we = 0; d_addr = 10'h0C0; #1;
        chk("rst_mid_dgnt", d_gnt, 1'b1);
        step(); d_req = 0; if_req = 1; #1;
        rst = 0; #1;
        chk("rst_mid_outputs",
            {if_gnt, d_gnt, if_rvalid, d_rvalid, stall_if, mem_en, mem_we,
             mem_addr, mem_funct3, mem_wdata, if_rdata, d_rdata}, '0);
        step(); if_req = 0;
        step(); rst = 1;
        for (int k = 0; k < 6; k++) begin
            step(); #1;
            chk("rst_abandoned", {d_rvalid, if_rvalid, d_gnt}, 3'b000);
        end

        // Randomized traffic with occasional resets
        for (int k = 0; k < 1500; k++) begin
            step();
            rst = ($urandom_range(0, 499) != 0);
            if (!if_req || m_if_gl) begin
                if_req  = ($urandom_range(0, 99) < 45);
                if_addr = AW'($urandom);
            end
            if (!d_req || m_d_gl) begin
                d_req    = ($urandom_range(0, 99) < 45);
                d_we     = 1'($urandom_range(0, 1));
                d_funct3 = 3'($urandom);
                d_addr   = AW'($urandom);
                d_wdata  = $urandom;
            end
            if_kill = ($urandom_range(0, 9) == 0);
        end
        step(); rst = 1;
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
